// File: rtl/zube_z80_frontend.sv
// Z80 I/O front-end for the zube mailbox: strobe synchronisation and de-glitch,
// port decode, single-cycle core requests and data-bus turnaround control.
//
// state     | meaning
// IDLE      | waiting for a qualified strobe
// WR_ACTIVE | write request issued, waiting for write strobe release
// RD_FETCH  | read request issued, latching core read data
// RD_ACTIVE | read in progress (bus driven if matched), waiting for release
// COLLIDE   | both strobes seen low, waiting for both to go high
module zube_z80_frontend #(
  parameter int unsigned     SYNC_STAGES   = 2,
  parameter int unsigned     FILTER_CYCLES = 2,
  parameter logic [7:0]      PORT_BASE     = 8'h00
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       z80_write_strobe_b_in,
  input  logic       z80_read_strobe_b_in,
  input  logic [7:0] z80_address_bus_in,
  input  logic [7:0] z80_data_bus_in,
  output logic [7:0] z80_data_bus_out,
  output logic       z80_bus_dir,
  output logic       wr_valid,
  output logic [1:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [1:0] rd_reg,
  input  logic [7:0] rd_data_in,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ACTIVE = 3'd1,
    RD_FETCH  = 3'd2,
    RD_ACTIVE = 3'd3,
    COLLIDE   = 3'd4
  } state_t;

  localparam logic [2:0] FILT = 3'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
  logic [7:0] addr_q1, addr_q2, data_q1, data_q2;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_s, rd_s, wr_low, rd_low, one_low, both_low, qual, matched;

  state_t     state_q, state_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_valid_q, rd_valid_d;
  logic       bus_err_q, bus_err_d;
  logic       dir_q, dir_d;
  logic [1:0] wr_reg_q, wr_reg_d, rd_reg_q, rd_reg_d;
  logic [7:0] wr_data_q, wr_data_d, dout_q, dout_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_sync_q <= '1;
      rd_sync_q <= '1;
      addr_q1   <= '0;
      addr_q2   <= '0;
      data_q1   <= '0;
      data_q2   <= '0;
      cnt_q     <= '0;
    end else begin
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], z80_write_strobe_b_in};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], z80_read_strobe_b_in};
      addr_q1   <= z80_address_bus_in;
      addr_q2   <= addr_q1;
      data_q1   <= z80_data_bus_in;
      data_q2   <= data_q1;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_s     = wr_sync_q[SYNC_STAGES-1];
  assign rd_s     = rd_sync_q[SYNC_STAGES-1];
  assign wr_low   = ~wr_s;
  assign rd_low   = ~rd_s;
  assign one_low  = wr_low ^ rd_low;
  assign both_low = wr_low & rd_low;
  assign matched  = (addr_q2[7:2] == PORT_BASE[7:2]);

  // Saturating run-length of single-strobe-low samples; fires once on reaching FILT.
  always_comb begin
    cnt_d = '0;
    if (one_low) cnt_d = (cnt_q == FILT) ? cnt_q : cnt_q + 3'd1;
  end

  assign qual = one_low && (cnt_q != FILT) && (cnt_d == FILT);

  always_comb begin
    state_d    = state_q;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    dir_d      = dir_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    rd_reg_d   = rd_reg_q;
    dout_d     = dout_q;
    case (state_q)
      IDLE: begin
        dir_d = 1'b0;
        if (both_low) begin
          bus_err_d = 1'b1;
          state_d   = COLLIDE;
        end else if (qual && wr_low) begin
          wr_reg_d   = addr_q2[1:0];
          wr_data_d  = data_q2;
          wr_valid_d = matched;
          state_d    = WR_ACTIVE;
        end else if (qual && rd_low) begin
          if (matched) begin
            rd_valid_d = 1'b1;
            rd_reg_d   = addr_q2[1:0];
            state_d    = RD_FETCH;
          end else begin
            state_d = RD_ACTIVE;
          end
        end
      end
      RD_FETCH: begin
        dout_d = rd_data_in;
        if (wr_low) begin
          bus_err_d = 1'b1;
          dir_d     = 1'b0;
          state_d   = COLLIDE;
        end else begin
          dir_d   = 1'b1;
          state_d = RD_ACTIVE;
        end
      end
      WR_ACTIVE: begin
        if (rd_low) begin
          bus_err_d = 1'b1;
          dir_d     = 1'b0;
          state_d   = COLLIDE;
        end else if (wr_s) begin
          state_d = IDLE;
        end
      end
      RD_ACTIVE: begin
        if (wr_low) begin
          bus_err_d = 1'b1;
          dir_d     = 1'b0;
          state_d   = COLLIDE;
        end else if (rd_s) begin
          dir_d   = 1'b0;
          state_d = IDLE;
        end
      end
      COLLIDE: begin
        dir_d = 1'b0;
        if (wr_s && rd_s) state_d = IDLE;
      end
      default: begin
        dir_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      dir_q      <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      rd_reg_q   <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
      dir_q      <= dir_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      rd_reg_q   <= rd_reg_d;
      dout_q     <= dout_d;
    end
  end

  // Gate the drive with the synchronised strobes so release/collision drop it on the sync edge.
  assign z80_bus_dir      = dir_q & rd_low & wr_s;
  assign z80_data_bus_out = dout_q;
  assign wr_valid         = wr_valid_q;
  assign wr_reg           = wr_reg_q;
  assign wr_data          = wr_data_q;
  assign rd_valid         = rd_valid_q;
  assign rd_reg           = rd_reg_q;
  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_zube_z80_frontend.sv
// Directed bench for zube_z80_frontend: write, read, glitch, mismatch,
// collision and mid-read reset, with a scoreboard of expected core requests.
module tb_zube_z80_frontend;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       wr_b, rd_b;
  logic [7:0] addr, din, dout, rd_data_in;
  logic       bus_dir, wr_valid, rd_valid, bus_err;
  logic [1:0] wr_reg, rd_reg;
  logic [7:0] wr_data;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] rg;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr = 0, n_rd = 0, n_err = 0;

  zube_z80_frontend #(.SYNC_STAGES(2), .FILTER_CYCLES(2), .PORT_BASE(8'h40)) dut (
    .clk                  (clk),
    .reset_b              (reset_b),
    .z80_write_strobe_b_in(wr_b),
    .z80_read_strobe_b_in (rd_b),
    .z80_address_bus_in   (addr),
    .z80_data_bus_in      (din),
    .z80_data_bus_out     (dout),
    .z80_bus_dir          (bus_dir),
    .wr_valid             (wr_valid),
    .wr_reg               (wr_reg),
    .wr_data              (wr_data),
    .rd_valid             (rd_valid),
    .rd_reg               (rd_reg),
    .rd_data_in           (rd_data_in),
    .bus_err              (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input logic [1:0] k, input logic [1:0] r, input logic [7:0] d);
    exp_t x;
    x.kind = k;
    x.rg   = r;
    x.dat  = d;
    return x;
  endfunction

  // Scoreboard: every request/error pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_b) begin
      if (wr_valid) begin
        n_wr++;
        chk("sb_wr_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          chk("sb_wr_kind", 32'(e_mon.kind), 32'(K_WR));
          chk("sb_wr_reg", 32'(wr_reg), 32'(e_mon.rg));
          chk("sb_wr_data", 32'(wr_data), 32'(e_mon.dat));
        end
      end
      if (rd_valid) begin
        n_rd++;
        chk("sb_rd_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          chk("sb_rd_kind", 32'(e_mon.kind), 32'(K_RD));
          chk("sb_rd_reg", 32'(rd_reg), 32'(e_mon.rg));
        end
      end
      if (bus_err) begin
        n_err++;
        chk("sb_err_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          chk("sb_err_kind", 32'(e_mon.kind), 32'(K_ERR));
        end
      end
    end
  end

  initial begin
    reset_b = 1'b0; wr_b = 1'b1; rd_b = 1'b1;
    addr = 8'h00; din = 8'h00; rd_data_in = 8'h00;
    tick(2);
    chk("rst_dir", 32'(bus_dir), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_wr_reg", 32'(wr_reg), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rd_reg", 32'(rd_reg), 0);
    reset_b = 1'b1;
    tick(2);

    // matched write, held for 10 cycles
    sb.push_back(mk(K_WR, 2'd2, 8'hA5));
    addr = 8'h42; din = 8'hA5; wr_b = 1'b0;
    tick(3);
    chk("wr_early", 32'(wr_valid), 0);
    tick(1);
    chk("wr_pulse", 32'(wr_valid), 1);
    chk("wr_reg", 32'(wr_reg), 2);
    chk("wr_data", 32'(wr_data), 'hA5);
    chk("wr_dir", 32'(bus_dir), 0);
    tick(1);
    chk("wr_single", 32'(wr_valid), 0);
    tick(5);
    chk("wr_count", n_wr, 1);
    chk("wr_dir_hold", 32'(bus_dir), 0);
    wr_b = 1'b1;
    tick(4);

    // matched read with turnaround and release
    rd_data_in = 8'h3C; addr = 8'h41;
    sb.push_back(mk(K_RD, 2'd1, 8'h00));
    rd_b = 1'b0;
    tick(4);
    chk("rd_pulse", 32'(rd_valid), 1);
    chk("rd_reg", 32'(rd_reg), 1);
    chk("rd_dir_e4", 32'(bus_dir), 0);
    tick(1);
    chk("rd_dir_e5", 32'(bus_dir), 1);
    chk("rd_dout", 32'(dout), 'h3C);
    chk("rd_single", 32'(rd_valid), 0);
    tick(4);
    chk("rd_count", n_rd, 1);
    chk("rd_dir_hold", 32'(bus_dir), 1);
    rd_b = 1'b1;
    tick(1);
    chk("rd_rel_e1", 32'(bus_dir), 1);
    tick(1);
    chk("rd_rel_e2", 32'(bus_dir), 0);
    chk("rd_dout_hold", 32'(dout), 'h3C);
    tick(3);

    // one-cycle write glitch
    wr_b = 1'b0;
    tick(1);
    wr_b = 1'b1;
    tick(6);
    chk("glitch_count", n_wr, 1);
    chk("glitch_dir", 32'(bus_dir), 0);

    // unmatched read
    addr = 8'h80; rd_b = 1'b0;
    tick(8);
    chk("mismatch_count", n_rd, 1);
    chk("mismatch_dir", 32'(bus_dir), 0);
    rd_b = 1'b1;
    tick(4);

    // read interrupted by a write strobe
    addr = 8'h41; rd_data_in = 8'h3C;
    sb.push_back(mk(K_RD, 2'd1, 8'h00));
    rd_b = 1'b0;
    tick(6);
    chk("coll_dir_before", 32'(bus_dir), 1);
    sb.push_back(mk(K_ERR, 2'd0, 8'h00));
    wr_b = 1'b0;
    tick(2);
    chk("coll_dir_drop", 32'(bus_dir), 0);
    chk("coll_err_early", 32'(bus_err), 0);
    tick(1);
    chk("coll_err_pulse", 32'(bus_err), 1);
    tick(1);
    chk("coll_err_single", 32'(bus_err), 0);
    chk("coll_err_count", n_err, 1);
    wr_b = 1'b1;
    tick(6);
    chk("coll_no_new_rd", n_rd, 2);
    chk("coll_dir_low", 32'(bus_dir), 0);
    rd_b = 1'b1;
    tick(4);
    addr = 8'h40; rd_data_in = 8'h5A;
    sb.push_back(mk(K_RD, 2'd0, 8'h00));
    rd_b = 1'b0;
    tick(4);
    chk("post_coll_rd", 32'(rd_valid), 1);
    chk("post_coll_rd_reg", 32'(rd_reg), 0);
    tick(1);
    chk("post_coll_dir", 32'(bus_dir), 1);
    chk("post_coll_dout", 32'(dout), 'h5A);
    tick(2);

    // async reset during RD_ACTIVE
    reset_b = 1'b0;
    #1;
    chk("arst_dir", 32'(bus_dir), 0);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_wr_valid", 32'(wr_valid), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_bus_err", 32'(bus_err), 0);
    chk("arst_wr_reg", 32'(wr_reg), 0);
    chk("arst_wr_data", 32'(wr_data), 0);
    chk("arst_rd_reg", 32'(rd_reg), 0);
    rd_b = 1'b1; addr = 8'h00;
    tick(2);
    reset_b = 1'b1;
    tick(2);

    // write after reset
    sb.push_back(mk(K_WR, 2'd2, 8'hA5));
    addr = 8'h42; din = 8'hA5; wr_b = 1'b0;
    tick(3);
    chk("pr_wr_early", 32'(wr_valid), 0);
    tick(1);
    chk("pr_wr_pulse", 32'(wr_valid), 1);
    chk("pr_wr_reg", 32'(wr_reg), 2);
    chk("pr_wr_data", 32'(wr_data), 'hA5);
    tick(6);
    chk("pr_wr_count", n_wr, 2);
    chk("pr_dir", 32'(bus_dir), 0);
    wr_b = 1'b1;
    tick(4);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
